pad_input_filter: RTL
=====================

// Module: pad_input_filter
// PURPOSE
//   Receive-side conditioner for bidirectional pad cells: takes the pad O (PAD->core)
//   signals of N_PADS pads and produces clean, glitch-filtered core-domain values.
//   Per channel: metastability synchroniser, programmable stability filter,
//   rise/fall edge pulses and sticky event flags.
//   Sits between the padframe and GPIO/peripheral logic inside the SoC domain.
// PARAMETERS
//   N_PADS       4   number of pad input channels
//   CNT_W        8   width of the filter threshold and counter
//   SYNC_STAGES  2   synchroniser flops per channel (>=2)
// PORTS
//   clk_i          in   1          core clock
//   rst_i          in   1          asynchronous reset, active high
//   pad_in_i       in   N_PADS     raw pad O outputs, asynchronous to clk_i
//   en_i           in   N_PADS     per-channel filter enable
//   filt_thresh_i  in   CNT_W      shared stability threshold T (quasi-static)
//   evt_clr_i      in   N_PADS     per-channel sticky event clear (1-cycle pulse)
//   val_o          out  N_PADS     filtered pad value
//   rise_o         out  N_PADS     1-cycle pulse in the first cycle val_o reads 1
//   fall_o         out  N_PADS     1-cycle pulse in the first cycle val_o reads 0
//   evt_o          out  N_PADS     sticky edge-seen flags
//   irq_o          out  1          OR of evt_o
// BEHAVIOUR
//   Reset (async, immediate): sync chain, val_o, counter, rise_o, fall_o, evt_o = 0;
//     irq_o = 0. Release takes effect at the next clk_i edge.
//   Synchroniser: pad_in_i -> SYNC_STAGES flops; s = last stage. Always runs, even with en_i=0.
//   Filter (per channel, en_i=1):
//     - s == val_o: cnt <= 0.
//     - s != val_o and cnt >= T: val_o <= s, cnt <= 0, matching edge pulse registered
//       together with val_o.
//     - s != val_o and cnt < T: cnt <= cnt + 1. cnt never exceeds T, so no wrap.
//     - A level must persist T+1 consecutive synchronised cycles to propagate.
//     - Pad edge to val_o latency: SYNC_STAGES + T + 1 cycles (T=0 -> 3 with defaults).
//     - T lowered below current cnt mid-count: >= compare, update on next differing cycle.
//       T raised mid-count: count continues to the new T.
//   en_i=0: val_o holds, cnt <= 0, rise_o/fall_o = 0, evt_o holds.
//     On re-enable, filtering resumes from the held val_o.
//   Edge pulses: rise_o/fall_o high exactly one cycle; never both in one cycle on one channel.
//   Sticky flags: evt_o[i] set when rise_o[i]|fall_o[i]; cleared by evt_clr_i[i].
//     Simultaneous set and clear: set wins. irq_o is combinational OR of evt_o.
//   Channels are fully independent; no cross-channel ordering.
// TESTING
//   1 T=3, ch0 pad 0->1 held: val_o[0]=1 at cycle 6 after edge; rise_o[0] one cycle;
//     evt_o[0]=1, irq_o=1.
//   2 T=3, ch1 glitch high 3 cycles then low: val_o[1] stays 0, no pulse.
//     Same glitch 4 cycles: val_o[1] pulses high for 4 cycles (rise, then fall).
//   3 T=0, ch2 toggles every 5 cycles: val_o[2] follows with 3-cycle latency;
//     alternating rise/fall pulses.
//   4 en_i[3]=0, pad toggles: val_o[3], evt_o[3] unchanged. en_i[3]=1 with pad differing:
//     val_o updates after T+1 cycles.
//   5 evt_clr_i[0] in the same cycle as a rise_o[0] pulse: evt_o[0] stays 1;
//     clear alone next cycle -> 0, irq_o -> 0 if no other flags.
//   6 rst_i asserted mid-count (cnt=2, T=5): all outputs 0 immediately.
//     After release with pad high: val_o=1 after 2+5+1 cycles.

Source files
------------

// File: rtl/pad_input_filter.sv
// Receive-side conditioner for pad inputs: per-channel synchroniser, stability
// filter, registered rise/fall pulses and sticky edge flags with a shared irq.
module pad_input_filter #(
    parameter int unsigned N_PADS      = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_PADS-1:0] pad_in_i,
    input  logic [N_PADS-1:0] en_i,
    input  logic [CNT_W-1:0]  filt_thresh_i,
    input  logic [N_PADS-1:0] evt_clr_i,
    output logic [N_PADS-1:0] val_o,
    output logic [N_PADS-1:0] rise_o,
    output logic [N_PADS-1:0] fall_o,
    output logic [N_PADS-1:0] evt_o,
    output logic              irq_o
);

    logic [N_PADS-1:0] sync_q [SYNC_STAGES];
    logic [N_PADS-1:0] sync_s;

    logic [CNT_W-1:0]  cnt_q [N_PADS];
    logic [CNT_W-1:0]  cnt_d [N_PADS];
    logic [N_PADS-1:0] val_d;
    logic [N_PADS-1:0] rise_d;
    logic [N_PADS-1:0] fall_d;
    logic [N_PADS-1:0] evt_d;

    // Synchroniser chain runs regardless of the per-channel enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Counter only advances while the synchronised level differs from val_o;
    // the >= compare lets a lowered threshold take effect on the next differing cycle.
    always_comb begin
        val_d  = val_o;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < N_PADS; i++) begin
            cnt_d[i] = '0;
            if (en_i[i] && (sync_s[i] != val_o[i])) begin
                if (cnt_q[i] >= filt_thresh_i) begin
                    val_d[i]  = sync_s[i];
                    rise_d[i] = sync_s[i];
                    fall_d[i] = ~sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Set from the visible pulse wins over a same-cycle clear.
        evt_d = (evt_o & ~evt_clr_i) | rise_o | fall_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_o  <= '0;
            rise_o <= '0;
            fall_o <= '0;
            evt_o  <= '0;
            for (int unsigned i = 0; i < N_PADS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            val_o  <= val_d;
            rise_o <= rise_d;
            fall_o <= fall_d;
            evt_o  <= evt_d;
            for (int unsigned i = 0; i < N_PADS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign irq_o = |evt_o;

endmodule
